// File: rtl/data_memory_mmio.sv
// Dual-port word RAM for the load/store path with a memory-mapped switch/GPIO window.
// Edge-capture interrupt logic is built only when GPIO_EDGE_CAPTURE_EN is defined.
module data_memory_mmio #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 24,
  parameter int QB_W         = 8,
  parameter int DEPTH        = 65536,
  parameter int MMIO_BASE    = 'h70000,
  parameter int SW_W         = 4,
  parameter int GPIO_CH      = 2,
  parameter int GPIO_W       = 18,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      memWrite,
  input  logic [ADDR_W-1:0]         address1,
  input  logic [DATA_W-1:0]         data1,
  input  logic [ADDR_W-1:0]         address2,
  input  logic [SW_W-1:0]           switches,
  input  logic [GPIO_CH*GPIO_W-1:0] gpioIn,
  output logic [DATA_W-1:0]         qa,
  output logic [QB_W-1:0]           qb,
  output logic [GPIO_CH*GPIO_W-1:0] gpioOut,
  output logic [GPIO_CH*GPIO_W-1:0] gpioOe,
  output logic                      irq
);
  localparam int GW     = GPIO_CH * GPIO_W;
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(MMIO_BASE);

  logic               in_ram_a;
  logic               in_ram_b;
  logic               in_mmio_a;
  logic               sel_sw;
  logic [ADDR_W-1:0]  off_a;
  logic [GPIO_CH-1:0] sel_data;
  logic [GPIO_CH-1:0] sel_dir;

  assign in_ram_a  = ({1'b0, address1} < (ADDR_W+1)'(DEPTH));
  assign in_ram_b  = ({1'b0, address2} < (ADDR_W+1)'(DEPTH));
  assign in_mmio_a = (address1 >= BASE_A);
  assign off_a     = address1 - BASE_A;
  assign sel_sw    = in_mmio_a && (off_a == '0);

  genvar gi;
  generate
    for (gi = 0; gi < GPIO_CH; gi = gi + 1) begin : g_sel
      assign sel_data[gi] = in_mmio_a && (off_a == ADDR_W'(2 + gi));
      assign sel_dir[gi]  = in_mmio_a && (off_a == ADDR_W'(16 + gi));
    end
  endgenerate

  // RAM: both ports read the pre-write contents when colliding with a port A write.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_a_q;
  logic [QB_W-1:0]   ram_b_q;
  logic              ram_we;

  assign ram_we = memWrite && !rst && in_ram_a;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[address1[RAM_AW-1:0]] <= data1;
    end
    ram_a_q <= mem[address1[RAM_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    ram_b_q <= mem[address2[RAM_AW-1:0]][QB_W-1:0];
  end

  logic [SW_W-1:0]  sw_meta_q;
  logic [SW_W-1:0]  sw_sync_q;
  logic [SW_W-1:0]  sw_q;
  logic [SW_W-1:0]  sw_d;
  logic [CNT_W-1:0] cnt_q [SW_W];
  logic [CNT_W-1:0] cnt_d [SW_W];
  logic [GW-1:0]    gpio_meta_q;
  logic [GW-1:0]    gpio_sync_q;

  // Accept a switch change only after DEBOUNCE_CYC consecutive differing cycles.
  always_comb begin
    sw_d = sw_q;
    for (int b = 0; b < SW_W; b++) begin
      cnt_d[b] = '0;
      if (sw_sync_q[b] != sw_q[b]) begin
        if (cnt_q[b] == CNT_W'(DEBOUNCE_CYC - 1)) begin
          sw_d[b] = ~sw_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      sw_q        <= '0;
      gpio_meta_q <= '0;
      gpio_sync_q <= '0;
      for (int b = 0; b < SW_W; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      sw_meta_q   <= switches;
      sw_sync_q   <= sw_meta_q;
      sw_q        <= sw_d;
      gpio_meta_q <= gpioIn;
      gpio_sync_q <= gpio_meta_q;
      for (int b = 0; b < SW_W; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  logic [GPIO_W-1:0] out_q   [GPIO_CH];
  logic [GPIO_W-1:0] out_d   [GPIO_CH];
  logic [GPIO_W-1:0] dir_q   [GPIO_CH];
  logic [GPIO_W-1:0] dir_d   [GPIO_CH];
  logic [GPIO_W-1:0] gpio_rd [GPIO_CH];

  always_comb begin
    for (int i = 0; i < GPIO_CH; i++) begin
      out_d[i] = out_q[i];
      dir_d[i] = dir_q[i];
      if (memWrite && sel_data[i]) begin
        out_d[i] = data1[GPIO_W-1:0];
      end
      if (memWrite && sel_dir[i]) begin
        dir_d[i] = data1[GPIO_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < GPIO_CH; i++) begin
      if (rst) begin
        out_q[i] <= '0;
        dir_q[i] <= '0;
      end else begin
        out_q[i] <= out_d[i];
        dir_q[i] <= dir_d[i];
      end
    end
  end

  // Output pins read back their driven value, input pins their synchronised pad.
  generate
    for (gi = 0; gi < GPIO_CH; gi = gi + 1) begin : g_gpio
      assign gpio_rd[gi] = (dir_q[gi] & out_q[gi]) |
                           (~dir_q[gi] & gpio_sync_q[gi*GPIO_W +: GPIO_W]);
      assign gpioOut[gi*GPIO_W +: GPIO_W] = out_q[gi];
      assign gpioOe[gi*GPIO_W +: GPIO_W]  = dir_q[gi];
    end
  endgenerate

`ifdef GPIO_EDGE_CAPTURE_EN
  localparam int EDGE_W = (GW < DATA_W) ? GW : DATA_W;

  logic              sel_edge;
  logic [EDGE_W-1:0] edge_q;
  logic [EDGE_W-1:0] edge_d;
  logic [EDGE_W-1:0] edge_clr;
  logic [EDGE_W-1:0] edge_rise;
  logic [EDGE_W-1:0] gpio_prev_q;
  logic              irq_q;

  assign sel_edge  = in_mmio_a && (off_a == ADDR_W'(1));
  assign edge_rise = gpio_sync_q[EDGE_W-1:0] & ~gpio_prev_q & ~gpioOe[EDGE_W-1:0];
  assign edge_clr  = (memWrite && sel_edge) ? data1[EDGE_W-1:0] : '0;
  // A rise in the same cycle as its clear keeps the bit set.
  assign edge_d    = (edge_q & ~edge_clr) | edge_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_prev_q <= '0;
      edge_q      <= '0;
      irq_q       <= 1'b0;
    end else begin
      gpio_prev_q <= gpio_sync_q[EDGE_W-1:0];
      edge_q      <= edge_d;
      irq_q       <= |edge_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  logic [DATA_W-1:0] mmio_rd_d;
  logic [DATA_W-1:0] mmio_rd_q;
  logic              sel_ram_q;
  logic              b_valid_q;

  always_comb begin
    mmio_rd_d = '0;
    if (sel_sw) begin
      mmio_rd_d = DATA_W'(sw_q);
    end
`ifdef GPIO_EDGE_CAPTURE_EN
    if (sel_edge) begin
      mmio_rd_d = DATA_W'(edge_q);
    end
`endif
    for (int i = 0; i < GPIO_CH; i++) begin
      if (sel_data[i]) begin
        mmio_rd_d = DATA_W'(gpio_rd[i]);
      end
      if (sel_dir[i]) begin
        mmio_rd_d = DATA_W'(dir_q[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mmio_rd_q <= '0;
      sel_ram_q <= 1'b0;
      b_valid_q <= 1'b0;
    end else begin
      mmio_rd_q <= mmio_rd_d;
      sel_ram_q <= in_ram_a;
      b_valid_q <= in_ram_b;
    end
  end

  assign qa = sel_ram_q ? ram_a_q : mmio_rd_q;
  assign qb = b_valid_q ? ram_b_q : '0;

endmodule

// File: doc/data_memory_mmio.md
Name: data_memory_mmio

Overview:
- Parametrised successor to the single-configuration data memory.
- Provides a dual-port word RAM for the core's load/store path plus a memory-mapped I/O window:
  - a debounced switch register;
  - GPIO_CH GPIO channels, each with a per-bit direction register.
- Port A is read/write and is used by the MEM stage.
- Port B is read-only. It feeds the display/VGA reader with a narrow slice of each word.

Parameters:
- ADDR_W, 19: word-address width of both ports.
- DATA_W, 24: port A data width.
- QB_W, 8: port B output width; port B returns RAM word bits [QB_W-1:0].
- DEPTH, 65536: number of RAM words, occupying addresses 0..DEPTH-1. Constraint: DEPTH <= MMIO_BASE.
- MMIO_BASE, 'h70000: base word address of the I/O window.
- SW_W, 4: switch count.
- GPIO_CH, 2: number of GPIO channels (1..8).
- GPIO_W, 18: bits per GPIO channel. Constraint: GPIO_W <= DATA_W.
- DEBOUNCE_CYC, 4: number of consecutive stable cycles before a switch change is accepted (>=1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- memWrite  in  1  port A write enable.
- address1  in  ADDR_W  port A word address.
- data1  in  DATA_W  port A write data.
- address2  in  ADDR_W  port B word address (read-only).
- switches  in  SW_W  asynchronous board switches.
- gpioIn  in  GPIO_CH*GPIO_W  pad input values; channel i occupies bits [i*GPIO_W +: GPIO_W].
- qa  out  DATA_W  port A read data.
- qb  out  QB_W  port B read data.
- gpioOut  out  GPIO_CH*GPIO_W  pad output values.
- gpioOe  out  GPIO_CH*GPIO_W  pad output enables (1 = drive).
- irq  out  1  edge-capture interrupt; tied 0 unless GPIO_EDGE_CAPTURE_EN is defined.

Behaviour:
- Address map (port A), all offsets relative to MMIO_BASE:
  - 0..DEPTH-1: RAM.
  - +0: SW register, read-only, zero-extended debounced switch value.
  - +1: EDGE status (see Optional Feature).
  - +2+i: GPIO_DATA[i].
  - +'h10+i: GPIO_DIR[i].
  - Any other address: read returns 0, write is ignored.
- Port B reads RAM only. Out-of-range address2 returns 0.
- Read latency: exactly 1 cycle on both ports. qa/qb are registered and reflect the address sampled at the previous rising edge.
- Read-during-write:
  - Port A reading the address it writes returns the OLD value.
  - Port B reading an address port A writes in the same cycle also returns the OLD value.
- Writes: on a rising edge with memWrite=1, the target is updated with data1 truncated to the target width (GPIO_W or RAM DATA_W). Writes to SW and to out-of-range addresses have no effect.
- GPIO_DATA[i] read, per bit: GPIO_DIR[i] bit = 1 returns the output register bit; bit = 0 returns the synchronised gpioIn bit. Upper DATA_W-GPIO_W bits read 0.
- gpioOut = GPIO_DATA output registers; gpioOe = GPIO_DIR registers.
- Input synchronisation: switches and gpioIn each pass through a 2-flop synchroniser. A gpioIn change is visible to a read issued 2 cycles after it.
- Switch debounce, per switch bit:
  - Counter increments while the synchronised bit differs from the accepted bit.
  - Counter resets to 0 on any cycle the bit equals the accepted bit.
  - When the counter reaches DEBOUNCE_CYC, the accepted bit toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYC cycles never changes SW.
- Reset (synchronous, active-high), applied at any time including mid-debounce or mid-write:
  - qa = 0, qb = 0, gpioOut = 0, gpioOe = 0 (all pins inputs), SW = 0, debounce counters = 0, synchronisers = 0, EDGE = 0, irq = 0.
  - A write presented in the same cycle as rst=1 is discarded.
  - RAM contents are NOT reset.

Optional Feature:
- Macro GPIO_EDGE_CAPTURE_EN.
- Defined:
  - Each synchronised gpioIn bit whose GPIO_DIR bit = 0 and which transitions 0->1 sets a sticky bit in EDGE.
  - EDGE layout: bit (i*GPIO_W+b), truncated to DATA_W.
  - Writing EDGE clears every bit written as 1 (write-1-to-clear). A set and a clear of the same bit in the same cycle leaves the bit set.
  - irq = OR of the EDGE bits, registered.
- Undefined: EDGE reads 0, writes to EDGE are ignored, irq is constant 0, and no edge logic is synthesised.

Test Plan:
- RAM round trip: write data1=255 to address1=5000; next cycle read 5000 -> qa=255 one cycle later. Then memWrite=0 with data1=27 -> qa stays 255.
- Dual-port and read-during-write: write 'h000102 to address 30 while address2=30 -> first qb=old value, following cycle qb='h02. Port A reading 30 during the write also returns the old value.
- Switch debounce (DEBOUNCE_CYC=4): switches 0->4'b1010 held 6 cycles -> SW reads 'hA. A 3-cycle pulse to 4'b1111 leaves SW at 'hA.
- GPIO: write GPIO_DIR[0]='h0000F and GPIO_DATA[0]='h00005 -> gpioOe[17:0]='h0000F, gpioOut[17:0]='h00005. With gpioIn[17:0]='h00030, GPIO_DATA[0] reads 'h00035 after synchroniser delay.
- Unmapped and reset: read MMIO_BASE+'h30 -> qa=0. Assert rst while memWrite=1 to GPIO_DATA[1] -> gpioOut=0 and gpioOe=0 afterwards, while RAM address 5000 still reads 255.
- Edge capture (macro defined): gpioIn bit 4 rises on an input pin -> EDGE bit 4=1, irq=1. Write 'h10 to EDGE -> EDGE=0, irq=0. With the macro undefined -> EDGE reads 0 and irq stays 0.
